// File: rtl/register_bank.sv
// 16 x 32-bit general-purpose register file with one synchronous write port
// and two independent combinational read ports. The reset is asynchronous and active-low.
module register_bank #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  EN,
   input  logic                  clk,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [ADDR_WIDTH-1:0] src1,
   input  logic [ADDR_WIDTH-1:0] src2,
   input  logic [DATA_WIDTH-1:0] Din,
   output logic [DATA_WIDTH-1:0] Dout1,
   output logic [DATA_WIDTH-1:0] Dout2,
   input  logic                  rst_n
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_regs [DEPTH];

   // Register storage: reset clears every entry, and the reset also overrides a write in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_regs[i] <= {DATA_WIDTH{1'b0}};
         end
      end else if (EN) begin
         r_regs[address] <= Din;
      end
   end

   // Read ports: no bypass from Din, so a same-index write becomes visible only after the edge.
   always_comb begin
      Dout1 = r_regs[src1];
      Dout2 = r_regs[src2];
   end

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank: stimulus queues expected read values,
// and a monitor process samples Dout1/Dout2 and compares them with those values.
module tb_register_bank;

   logic        EN;
   logic        clk;
   logic [3:0]  address;
   logic [3:0]  src1;
   logic [3:0]  src2;
   logic [31:0] Din;
   logic [31:0] Dout1;
   logic [31:0] Dout2;
   logic        rst_n;

   typedef struct {
      string       name;
      int          port;
      logic [31:0] exp;
   } sb_entry_t;

   sb_entry_t sb_q[$];
   event      chk_ev;
   int        n_checks = 0;
   int        n_pass   = 0;

   register_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
      .EN(EN), .clk(clk), .address(address), .src1(src1), .src2(src2),
      .Din(Din), .Dout1(Dout1), .Dout2(Dout2), .rst_n(rst_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: on each sample request, drain the scoreboard against the live outputs
   initial begin
      sb_entry_t   e;
      logic [31:0] act;
      forever begin
         @(chk_ev);
         #1;
         while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = (e.port == 1) ? Dout1 : Dout2;
            n_checks++;
            if (act === e.exp) n_pass++;
            else $display("FAIL %s port%0d: got %h expected %h", e.name, e.port, act, e.exp);
         end
      end
   end

   task automatic expect2(input string nm, input logic [31:0] e1, input logic [31:0] e2);
      sb_q.push_back('{nm, 1, e1});
      sb_q.push_back('{nm, 2, e2});
      -> chk_ev;
      #2;
   endtask

   task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      EN = 1'b1; address = a; Din = d;
      @(posedge clk);
      #1;
      EN = 1'b0;
   endtask

   task automatic set_src(input logic [3:0] s1, input logic [3:0] s2);
      @(negedge clk);
      src1 = s1; src2 = s2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      EN = 1'b0; address = 4'd0; src1 = 4'd0; src2 = 4'd0; Din = 32'h0; rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      expect2("in_reset", 32'h0, 32'h0);

      // A write attempted while reset is held must be blocked
      @(negedge clk);
      EN = 1'b1; address = 4'd0; Din = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      EN = 1'b0;
      expect2("write_blocked_in_reset", 32'h0, 32'h0);

      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      expect2("idle_after_reset", 32'h0, 32'h0);

      write_reg(4'd1, 32'h4256_8399);
      set_src(4'd1, 4'd0);
      expect2("write1", 32'h4256_8399, 32'h0);

      write_reg(4'd2, 32'h0027_11a8);
      set_src(4'd2, 4'd1);
      expect2("write2", 32'h0027_11a8, 32'h4256_8399);

      write_reg(4'd3, 32'h0002_2231);
      set_src(4'd3, 4'd3);
      expect2("write3_same_src", 32'h0002_2231, 32'h0002_2231);

      // A write with EN low must leave reg1 untouched
      @(negedge clk);
      EN = 1'b0; address = 4'd1; Din = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      set_src(4'd1, 4'd2);
      expect2("en_low_no_write", 32'h4256_8399, 32'h0027_11a8);

      // Read during a write to the same index: old value before the edge, new value after it
      @(negedge clk);
      src1 = 4'd5; src2 = 4'd5;
      EN = 1'b1; address = 4'd5; Din = 32'hA5A5_A5A5;
      expect2("rdw_before_edge", 32'h0, 32'h0);
      @(posedge clk); #1;
      EN = 1'b0;
      expect2("rdw_after_edge", 32'hA5A5_A5A5, 32'hA5A5_A5A5);

      for (int i = 0; i < 16; i++) write_reg(i[3:0], 32'h1000_0000 + i);
      for (int i = 0; i < 16; i++) begin
         set_src(i[3:0], 4'(15 - i));
         expect2($sformatf("all_regs_%0d", i), 32'h1000_0000 + i, 32'h1000_0000 + (15 - i));
      end

      // Reset pulsed between edges clears the outputs at once and overrides a pending write
      @(negedge clk);
      src1 = 4'd7; src2 = 4'd0;
      EN = 1'b1; address = 4'd7; Din = 32'hDEAD_BEEF;
      #2 rst_n = 1'b0;
      #1;
      expect2("reset_pulse_immediate", 32'h0, 32'h0);
      @(posedge clk); #1;
      expect2("reset_overrides_write", 32'h0, 32'h0);
      @(negedge clk);
      EN = 1'b0;
      rst_n = 1'b1;
      #1;
      set_src(4'd15, 4'd1);
      expect2("cleared_after_reset", 32'h0, 32'h0);

      #5;
      n_checks++;
      if (sb_q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
